regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file for the dual-issue core: NUM_RD combinational read ports,
//  NUM_WR write ports with same-cycle write-to-read bypass, a per-register pending scoreboard
//  for the issue stage, and a post-reset zeroing sequencer. It replaces the 2R/1W file

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: reset/enable polarities,
// default index width and the init FSM state codes.
package regfile_mp_pkg;

    localparam logic        RST_ENABLE_N = 1'b0;
    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam logic        READ_ENABLE  = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;

    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_READY = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports,
// read-busy flags and the issue-stage allocation request.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     alloc_vld;
    logic [ADDR_W-1:0]        alloc_addr;

    modport master (
        output we, waddr, wdata, re, raddr, alloc_vld, alloc_addr,
        input  rdata, rbusy
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, alloc_vld, alloc_addr,
        output rdata, rbusy
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending flags for the issue stage: writes clear, allocation sets,
// and a same-cycle set wins over a clear because the new producer is in flight.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic                     alloc_vld,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [(1<<ADDR_W)-1:0]   pending
);
    logic [(1<<ADDR_W)-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        if (en) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] != '0)
                    pending_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
            if (alloc_vld && alloc_addr != '0)
                pending_nxt[alloc_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N)
            pending <= '0;
        else
            pending <= pending_nxt;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: zeroing sequencer after reset, prioritised write ports,
// combinational read ports with optional write bypass, and a pending scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = REG_NUM_LOG2,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic         init_done,
    regfile_mp_if.slave  bus
);
    localparam int REG_N = 2**ADDR_W;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [REG_N];
    logic [REG_N-1:0]  pending;
    logic              ready;

    assign ready = (state == ST_READY);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            state     <= ST_INIT;
            cnt       <= ADDR_W'(1);
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(REG_N - 1)) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end
    end

    // Array has no reset; ascending loop lets the highest write port win.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[cnt] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (bus.we[k] == WRITE_ENABLE && bus.waddr[k*ADDR_W +: ADDR_W] != '0)
                    regs[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .en         (ready),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .alloc_vld  (bus.alloc_vld),
        .alloc_addr (bus.alloc_addr),
        .pending    (pending)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] byp;
        logic [DATA_W-1:0] rd;

        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (bus.we[k] == WRITE_ENABLE && bus.waddr[k*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    byp = bus.wdata[k*DATA_W +: DATA_W];
                end
            end
        end

        always_comb begin
            if (rst == RST_ENABLE_N || !init_done || ra == '0 || bus.re[i] != READ_ENABLE)
                rd = '0;
            else if (BYPASS != 0 && hit)
                rd = byp;
            else
                rd = regs[ra];
        end

        assign bus.rdata[i*DATA_W +: DATA_W] = rd;
        assign bus.rbusy[i] = init_done && bus.re[i] == READ_ENABLE && ra != '0
                              && pending[ra] && !(BYPASS != 0 && hit);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp (bypass and non-bypass builds)
// against a behavioural array/scoreboard model.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_done1, init_done0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem  [32];
    logic        m_pend [32];
    bit          m_init;
    int          m_cnt;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)) bus1 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2)) bus0 ();

    assign bus0.we         = bus1.we;
    assign bus0.waddr      = bus1.waddr;
    assign bus0.wdata      = bus1.wdata;
    assign bus0.re         = bus1.re;
    assign bus0.raddr      = bus1.raddr;
    assign bus0.alloc_vld  = bus1.alloc_vld;
    assign bus0.alloc_addr = bus1.alloc_addr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .init_done(init_done1), .bus(bus1.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .init_done(init_done0), .bus(bus0.slave));

    function automatic logic [31:0] model_rd(input int byp, input int i);
        logic [4:0]  ra;
        logic [31:0] r;
        bit          hit;
        ra = bus1.raddr[i*5 +: 5];
        if (!m_init || !rst || ra == 5'd0 || !bus1.re[i]) return 32'd0;
        hit = 0;
        r = 32'd0;
        for (int k = 0; k < 2; k++)
            if (bus1.we[k] && bus1.waddr[k*5 +: 5] == ra) begin
                hit = 1;
                r = bus1.wdata[k*32 +: 32];
            end
        if (byp != 0 && hit) return r;
        return m_mem[ra];
    endfunction

    function automatic logic model_busy(input int byp, input int i);
        logic [4:0] ra;
        ra = bus1.raddr[i*5 +: 5];
        if (!m_init || ra == 5'd0 || !bus1.re[i]) return 1'b0;
        if (byp != 0)
            for (int k = 0; k < 2; k++)
                if (bus1.we[k] && bus1.waddr[k*5 +: 5] == ra) return 1'b0;
        return m_pend[ra];
    endfunction

    task automatic clear_inputs();
        bus1.we = '0; bus1.waddr = '0; bus1.wdata = '0;
        bus1.re = '0; bus1.raddr = '0;
        bus1.alloc_vld = 1'b0; bus1.alloc_addr = '0;
    endtask

    task automatic rand_inputs(input int amax);
        bus1.we    = 2'($urandom_range(0, 3));
        bus1.re    = 4'($urandom_range(0, 15));
        bus1.wdata = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) bus1.waddr[k*5 +: 5] = 5'($urandom_range(0, amax));
        for (int i = 0; i < 4; i++) bus1.raddr[i*5 +: 5] = 5'($urandom_range(0, amax));
        bus1.alloc_vld  = ($urandom_range(0, 2) == 0);
        bus1.alloc_addr = 5'($urandom_range(0, amax));
    endtask

    // One rising edge: advance the reference model, then return at the falling edge.
    task automatic tick();
        logic [4:0] wa;
        @(posedge clk);
        if (rst) begin
            if (!m_init) begin
                m_cnt++;
                if (m_cnt == 31) begin
                    m_init = 1;
                    for (int a = 0; a < 32; a++) m_mem[a] = 32'd0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    wa = bus1.waddr[k*5 +: 5];
                    if (bus1.we[k] && wa != 5'd0) begin
                        m_mem[wa]  = bus1.wdata[k*32 +: 32];
                        m_pend[wa] = 1'b0;
                    end
                end
                if (bus1.alloc_vld && bus1.alloc_addr != 5'd0) m_pend[bus1.alloc_addr] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_init = 0;
        m_cnt  = 0;
        for (int a = 0; a < 32; a++) m_pend[a] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus1.re = 4'hF;
        bus1.raddr = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        n_vec++;
        if (init_done1 !== 1'b0 || init_done0 !== 1'b0 || bus1.rdata !== '0 || bus1.rbusy !== '0) begin
            n_err++;
            $display("FAIL reset_state: init_done=%b/%b rdata=%h rbusy=%b, required 0", init_done1, init_done0, bus1.rdata, bus1.rbusy);
        end
        rst = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            rand_inputs(31);
            #1;
            n_vec++;
            if (bus1.rdata !== '0 || bus0.rdata !== '0 || bus1.rbusy !== '0 || bus0.rbusy !== '0) begin
                n_err++;
                $display("FAIL init_reads edge %0d: rdata=%h/%h rbusy=%b/%b, required 0", e, bus1.rdata, bus0.rdata, bus1.rbusy, bus0.rbusy);
            end
            tick();
            n_vec++;
            if (init_done1 !== (e == 31) || init_done0 !== (e == 31)) begin
                n_err++;
                $display("FAIL init_done edge %0d: got %b/%b required %b", e, init_done1, init_done0, e == 31);
            end
        end
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            bus1.re = 4'hF;
            for (int i = 0; i < 4; i++) bus1.raddr[i*5 +: 5] = 5'($urandom_range(1, 31));
            #1;
            n_vec++;
            if (bus1.rdata !== '0 || bus0.rdata !== '0 || bus1.rbusy !== '0) begin
                n_err++;
                $display("FAIL zeroed_array: rdata=%h/%h rbusy=%b, required 0", bus1.rdata, bus0.rdata, bus1.rbusy);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        bus1.we[0] = 1'b1; bus1.waddr[4:0] = 5'd3; bus1.wdata[31:0] = 32'hA5A5_0001;
        bus1.re[0] = 1'b1; bus1.raddr[4:0] = 5'd3;
        #1;
        n_vec++;
        if (bus1.rdata[31:0] !== 32'hA5A5_0001 || bus0.rdata[31:0] !== 32'd0) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h/%h required a5a50001/00000000", bus1.rdata[31:0], bus0.rdata[31:0]);
        end
        tick();
        clear_inputs();
        bus1.re[0] = 1'b1; bus1.raddr[4:0] = 5'd3;
        #1;
        n_vec++;
        if (bus1.rdata[31:0] !== 32'hA5A5_0001 || bus0.rdata[31:0] !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL write_stored: got %h/%h required a5a50001", bus1.rdata[31:0], bus0.rdata[31:0]);
        end
        tick();
    endtask

    task automatic test_priority();
        clear_inputs();
        bus1.we = 2'b11;
        bus1.waddr = {5'd7, 5'd7};
        bus1.wdata = {32'h22, 32'h11};
        bus1.re[2] = 1'b1; bus1.raddr[14:10] = 5'd7;
        #1;
        n_vec++;
        if (bus1.rdata[95:64] !== 32'h22 || bus0.rdata[95:64] !== m_mem[7]) begin
            n_err++;
            $display("FAIL priority_bypass: got %h/%h required 00000022/%h", bus1.rdata[95:64], bus0.rdata[95:64], m_mem[7]);
        end
        tick();
        clear_inputs();
        bus1.re[1] = 1'b1; bus1.raddr[9:5] = 5'd7;
        #1;
        n_vec++;
        if (bus1.rdata[63:32] !== 32'h22 || bus0.rdata[63:32] !== 32'h22) begin
            n_err++;
            $display("FAIL priority_write: got %h/%h required 00000022", bus1.rdata[63:32], bus0.rdata[63:32]);
        end
        tick();
    endtask

    task automatic test_reg0();
        clear_inputs();
        bus1.we = 2'b11; bus1.waddr = '0; bus1.wdata = '1;
        bus1.alloc_vld = 1'b1; bus1.alloc_addr = 5'd0;
        bus1.re = 4'hF; bus1.raddr = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (bus1.rdata !== '0 || bus0.rdata !== '0 || bus1.rbusy !== '0 || bus0.rbusy !== '0) begin
                n_err++;
                $display("FAIL reg0 cycle %0d: rdata=%h/%h rbusy=%b/%b required 0", c, bus1.rdata, bus0.rdata, bus1.rbusy, bus0.rbusy);
            end
            tick();
            bus1.we = '0; bus1.alloc_vld = 1'b0;
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        bus1.alloc_vld = 1'b1; bus1.alloc_addr = 5'd9;
        tick();
        clear_inputs();
        bus1.re[0] = 1'b1; bus1.raddr[4:0] = 5'd9;
        #1;
        n_vec++;
        if (bus1.rbusy[0] !== 1'b1 || bus0.rbusy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_alloc: got %b/%b required 1/1", bus1.rbusy[0], bus0.rbusy[0]);
        end
        bus1.we[0] = 1'b1; bus1.waddr[4:0] = 5'd9; bus1.wdata[31:0] = 32'h5;
        #1;
        n_vec++;
        if (bus1.rbusy[0] !== 1'b0 || bus1.rdata[31:0] !== 32'h5 || bus0.rbusy[0] !== 1'b1 || bus0.rdata[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL busy_bypass: rbusy=%b/%b rdata=%h/%h required 0/1 5/0", bus1.rbusy[0], bus0.rbusy[0], bus1.rdata[31:0], bus0.rdata[31:0]);
        end
        tick();
        bus1.we = '0;
        #1;
        n_vec++;
        if (bus1.rbusy[0] !== 1'b0 || bus0.rbusy[0] !== 1'b0 || bus0.rdata[31:0] !== 32'h5) begin
            n_err++;
            $display("FAIL busy_cleared: rbusy=%b/%b rdata=%h required 0/0 5", bus1.rbusy[0], bus0.rbusy[0], bus0.rdata[31:0]);
        end
        bus1.re = '0;
        bus1.we[0] = 1'b1; bus1.wdata[31:0] = 32'h6;
        bus1.alloc_vld = 1'b1; bus1.alloc_addr = 5'd9;
        tick();
        clear_inputs();
        bus1.re[3] = 1'b1; bus1.raddr[19:15] = 5'd9;
        #1;
        n_vec++;
        if (bus1.rbusy[3] !== 1'b1 || bus0.rbusy[3] !== 1'b1 || bus1.rdata[127:96] !== 32'h6) begin
            n_err++;
            $display("FAIL set_beats_clear: rbusy=%b/%b rdata=%h required 1/1 6", bus1.rbusy[3], bus0.rbusy[3], bus1.rdata[127:96]);
        end
        tick();
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] a1, a0;
        for (int c = 0; c < cycles; c++) begin
            rand_inputs(($urandom_range(0, 3) == 0) ? 31 : 7);
            #1;
            for (int i = 0; i < 4; i++) begin
                a1 = bus1.rdata[i*32 +: 32];
                a0 = bus0.rdata[i*32 +: 32];
                n_vec++;
                if (a1 !== model_rd(1, i) || a0 !== model_rd(0, i) ||
                    bus1.rbusy[i] !== model_busy(1, i) || bus0.rbusy[i] !== model_busy(0, i)) begin
                    n_err++;
                    $display("FAIL random c%0d p%0d: rdata=%h/%h rbusy=%b/%b required %h/%h %b/%b", c, i,
                             a1, a0, bus1.rbusy[i], bus0.rbusy[i], model_rd(1, i), model_rd(0, i), model_busy(1, i), model_busy(0, i));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_init();
        clear_inputs();
        bus1.alloc_vld = 1'b1; bus1.alloc_addr = 5'd4;
        bus1.we[0] = 1'b1; bus1.waddr[4:0] = 5'd5; bus1.wdata[31:0] = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            rand_inputs(31);
            bus1.we = 2'b11;
            tick();
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (init_done1 !== 1'b0 || init_done0 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_init_reset: init_done=%b/%b required 0", init_done1, init_done0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            rand_inputs(31);
            bus1.we = 2'b11;
            tick();
            n_vec++;
            if (init_done1 !== (e == 31) || init_done0 !== (e == 31)) begin
                n_err++;
                $display("FAIL reinit_done edge %0d: got %b/%b required %b", e, init_done1, init_done0, e == 31);
            end
        end
        clear_inputs();
        bus1.re = 4'hF;
        bus1.raddr = {5'd5, 5'd4, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
        #1;
        n_vec++;
        if (bus1.rdata !== '0 || bus0.rdata !== '0 || bus1.rbusy !== '0 || bus0.rbusy !== '0) begin
            n_err++;
            $display("FAIL init_writes_lost: rdata=%h/%h rbusy=%b/%b required 0", bus1.rdata, bus0.rdata, bus1.rbusy, bus0.rbusy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_reg0();
        test_scoreboard();
        test_random(400);
        test_reset_mid_init();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
